hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the 5-stage RISC-V core. Combines load-use hazard detection, taken-branch flush and data-memory wait handling into one prioritised set of PC/pipeline-register enables and flushes. It sits beside the forwarding logic in ID/EX and drives the PC, IF/ID, ID/EX and EX/MEM/MEM/WB register controls. It also runs a wait-timeout FSM and a saturating stall-cycle performance counter.

## Interface

Parameters:
- MEM_TIMEOUT, 64: consecutive MEM_WAIT cycles with dmem_ready_i low before entering ERROR (≥2).
- WAIT_CNT_W, 7: width of the wait counter; must hold MEM_TIMEOUT-1.
- STALL_CNT_W, 16: width of stall_cycles_o.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- id_ex_memread_i  in  1  instruction in EX is a load.
- id_ex_register_rd_i  in  5  destination register of the instruction in EX.
- if_id_register_rs1_i  in  5  rs1 of the instruction in ID.
- if_id_register_rs2_i  in  5  rs2 of the instruction in ID.
- if_id_uses_rs1_i  in  1  ID instruction reads rs1.
- if_id_uses_rs2_i  in  1  ID instruction reads rs2.
- ex_branch_taken_i  in  1  branch/jump resolved taken in EX.
- dmem_req_i  in  1  MEM-stage instruction is accessing data memory.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID load enable.
- if_id_flush_o  out  1  IF/ID loads a NOP.
- id_ex_flush_o  out  1  ID/EX loads a bubble (all control bits 0).
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB; suppress register-file write.
- mem_timeout_o  out  1  sticky error: memory never answered.
- stall_cycles_o  out  STALL_CNT_W  saturating count of cycles with pc_write_o=0.

## Operation

- Load-use hazard: `lu` = id_ex_memread_i && rd≠0 && ((uses_rs1 && rd==rs1) || (uses_rs2 && rd==rs2)).
- Memory wait: `mw` = (state==RUN && dmem_req_i && !dmem_ready_i) || (state==MEM_WAIT && !dmem_ready_i).
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN→MEM_WAIT: dmem_req_i && !dmem_ready_i; clears wait_cnt to 0.
  - MEM_WAIT→RUN: dmem_ready_i.
  - MEM_WAIT with !dmem_ready_i: if wait_cnt==MEM_TIMEOUT-1, go to ERROR; else wait_cnt+1.
  - ERROR: terminal until reset.
- Output priority, highest first; all outputs are combinational from state and inputs:
  1. ERROR: pc_write_o=0, if_id_write_o=0, pipe_freeze_o=1, both flushes 0, mem_timeout_o=1.
  2. `mw`: pc_write_o=0, if_id_write_o=0, pipe_freeze_o=1, both flushes 0. A simultaneous branch or load-use is deferred; frozen inputs re-present it after release.
  3. ex_branch_taken_i: pc_write_o=1, if_id_write_o=1, if_id_flush_o=1, id_ex_flush_o=1. Any load-use on the squashed ID instruction is ignored.
  4. `lu`: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, if_id_flush_o=0.
  5. Otherwise: pc_write_o=1, if_id_write_o=1, all other control outputs 0.
- stall_cycles_o increments by 1 on each edge where pc_write_o=0, including ERROR cycles. It holds at 2^STALL_CNT_W-1.

## Timing

- Hazard outputs have zero latency: combinational from the same-cycle inputs.
- Load-use inserts exactly one bubble. On the next cycle the load is in MEM, so `lu` deasserts and no second bubble occurs.
- Memory wait: freeze lasts while dmem_ready_i=0. In the cycle dmem_ready_i=1, pipe_freeze_o=0 and the pipeline advances.
- Timeout: MEM_TIMEOUT+1 consecutive not-ready cycles (1 in RUN plus MEM_TIMEOUT in MEM_WAIT). mem_timeout_o asserts on the following cycle.
- While rst_n_i=0, sampled on the edge, the state goes to RUN and wait_cnt and stall_cycles_o go to 0.
  - During the reset cycles the outputs are forced: pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_flush_o=1, pipe_freeze_o=0, mem_timeout_o=0.
- Reset asserted during MEM_WAIT or ERROR returns to RUN on that edge.
- dmem_ready_i with dmem_req_i=0 in RUN is ignored.

## Test plan

- Load-use: memread=1, rd=5, rs1=5, uses_rs1=1 → for one cycle pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; stall_cycles_o goes 0→1.
- x0 and unused operand: rd=0, rs1=0 → no stall. rd=7, rs2=7, uses_rs2=0 → no stall.
- Branch plus load-use in the same cycle → pc_write_o=1, both flushes 1; stall_cycles_o unchanged.
- Memory wait of 3 cycles: dmem_req_i=1, dmem_ready_i low for 3 cycles then high → pipe_freeze_o=1 for exactly 3 cycles, a concurrent branch is held off, state returns to RUN, stall_cycles_o=3.
- Timeout with MEM_TIMEOUT=8: ready held low 9 cycles → mem_timeout_o=1 on cycle 10 and stays 1 with ready high. rst_n_i=0 for one edge → mem_timeout_o=0, stall_cycles_o=0.
- Saturation with STALL_CNT_W=4: 20 load-use stall cycles → stall_cycles_o=15 and holds.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush and data-memory wait freeze,
// with a wait-timeout FSM and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned WAIT_CNT_W  = 7,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   id_ex_memread_i,
  input  logic [4:0]             id_ex_register_rd_i,
  input  logic [4:0]             if_id_register_rs1_i,
  input  logic [4:0]             if_id_register_rs2_i,
  input  logic                   if_id_uses_rs1_i,
  input  logic                   if_id_uses_rs2_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ready_i,
  output logic                   pc_write_o,
  output logic                   if_id_write_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   pipe_freeze_o,
  output logic                   mem_timeout_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                  state_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;
  logic                    load_use;
  logic                    mem_wait;

  always_comb begin
    load_use = id_ex_memread_i && (id_ex_register_rd_i != 5'd0) &&
               ((if_id_uses_rs1_i && (id_ex_register_rd_i == if_id_register_rs1_i)) ||
                (if_id_uses_rs2_i && (id_ex_register_rd_i == if_id_register_rs2_i)));
    mem_wait = ((state_q == RUN) && dmem_req_i && !dmem_ready_i) ||
               ((state_q == MEM_WAIT) && !dmem_ready_i);
  end

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pipe_freeze_o = 1'b0;
    mem_timeout_o = 1'b0;
    if (!rst_n_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (state_q == ERROR) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_freeze_o = 1'b1;
      mem_timeout_o = 1'b1;
    end else if (mem_wait) begin
      // Branch/load-use are held off; frozen pipeline re-presents them after release.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      pipe_freeze_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (dmem_req_i && !dmem_ready_i) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i) begin
            state_q <= RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q <= ERROR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ERROR:   state_q <= ERROR;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned T  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memread;
  logic [4:0]    rd, rs1, rs2;
  logic          u1, u2, br, req, rdy;
  logic          pc_w, ifid_w, ifid_fl, idex_fl, frz, tmo;
  logic [SW-1:0] stall;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model state: consecutive not-ready cycles of the current data access, error flag, stall count.
  int unsigned m_consec = 0;
  bit          m_err = 1'b0;
  int unsigned m_stall = 0;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .MEM_TIMEOUT(T),
    .WAIT_CNT_W (3),
    .STALL_CNT_W(SW)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .id_ex_memread_i     (memread),
    .id_ex_register_rd_i (rd),
    .if_id_register_rs1_i(rs1),
    .if_id_register_rs2_i(rs2),
    .if_id_uses_rs1_i    (u1),
    .if_id_uses_rs2_i    (u2),
    .ex_branch_taken_i   (br),
    .dmem_req_i          (req),
    .dmem_ready_i        (rdy),
    .pc_write_o          (pc_w),
    .if_id_write_o       (ifid_w),
    .if_id_flush_o       (ifid_fl),
    .id_ex_flush_o       (idex_fl),
    .pipe_freeze_o       (frz),
    .mem_timeout_o       (tmo),
    .stall_cycles_o      (stall)
  );

  // Expected control word {pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, timeout}.
  function automatic logic [5:0] model_ctrl();
    bit lu, mw;
    lu = memread && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    mw = !rdy && (m_consec > 0 || req);
    if (!rst_n)      return 6'b001100;
    else if (m_err)  return 6'b000011;
    else if (mw)     return 6'b000010;
    else if (br)     return 6'b111100;
    else if (lu)     return 6'b000100;
    else             return 6'b110000;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [5:0] e;
    e = model_ctrl();
    vectors++;
    if ({pc_w, ifid_w, ifid_fl, idex_fl, frz, tmo} != e) begin
      miscompares++;
      $display("FAIL ctrl: got %b expected %b at %0t",
               {pc_w, ifid_w, ifid_fl, idex_fl, frz, tmo}, e, $time);
    end
    if (m_valid && rst_n) chk("stall_cycles", stall, m_stall);
  endtask

  task automatic drive(input bit r, input bit mr, input int unsigned d, input int unsigned s1,
                       input int unsigned s2, input bit a1, input bit a2, input bit b,
                       input bit q, input bit y);
    rst_n = r; memread = mr; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    u1 = a1; u2 = a2; br = b; req = q; rdy = y;
    #4;
    compare_model();
  endtask

  task automatic tick();
    logic [5:0] e;
    bit mw;
    @(posedge clk);
    e  = model_ctrl();
    mw = !rdy && (m_consec > 0 || req);
    if (!rst_n) begin
      m_err = 0; m_consec = 0; m_stall = 0; m_valid = 1;
    end else begin
      if (!e[5] && m_stall < (1 << SW) - 1) m_stall++;
      if (!m_err) begin
        if (mw) begin
          m_consec++;
          if (m_consec == T + 1) m_err = 1;
        end else begin
          m_consec = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_write", pc_w, 0);
    chk("rst_flushes", {ifid_fl, idex_fl}, 3);
    chk("rst_freeze_tmo", {frz, tmo}, 0);
    tick();
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    do_reset();
    idle();
    chk("reset_stall", stall, 0);
    tick();

    // Single load-use bubble
    drive(1, 1, 5, 5, 0, 1, 0, 0, 0, 0);
    chk("lu_pc_write", pc_w, 0);
    chk("lu_idex_flush", idex_fl, 1);
    tick();
    idle();
    chk("lu_stall_count", stall, 1);
    chk("lu_released", pc_w, 1);
    tick();

    // x0 destination and unused operand never stall
    drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("x0_no_stall", pc_w, 1);
    tick();
    drive(1, 1, 7, 0, 7, 0, 0, 0, 0, 0);
    chk("unused_rs2_no_stall", pc_w, 1);
    tick();

    // Branch overrides load-use
    drive(1, 1, 5, 5, 0, 1, 0, 1, 0, 0);
    chk("br_lu_ctrl", {pc_w, ifid_fl, idex_fl}, 7);
    tick();
    idle();
    chk("br_lu_stall_unchanged", stall, 1);
    tick();

    // Three-cycle memory wait with a concurrent branch held off
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("mw_freeze", {frz, pc_w, ifid_fl}, 4);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("mw_release", {frz, pc_w, ifid_fl}, 3);
    chk("mw_stall_count", stall, 3);
    tick();

    // Timeout after T+1 not-ready cycles
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("to_pending", {frz, tmo}, 2);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("to_asserted", {frz, tmo}, 3);
    tick();
    idle();
    chk("to_sticky", tmo, 1);
    tick();
    do_reset();
    idle();
    chk("to_cleared", tmo, 0);
    chk("to_stall_cleared", stall, 0);
    tick();

    // Stall counter saturation
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 3, 0, 3, 0, 1, 0, 0, 0);
      tick();
    end
    idle();
    chk("stall_saturated", stall, 15);
    tick();

    // Randomized traffic; rdy bias switches per phase so timeouts and long waits occur
    for (int p = 0; p < 60; p++) begin
      int unsigned rdy_pct;
      rdy_pct = (p % 4 == 0) ? 5 : $urandom_range(30, 90);
      for (int c = 0; c < 32; c++) begin
        drive(($urandom_range(0, 99) >= 2), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), ($urandom_range(0, 99) < 20), $urandom_range(0, 1),
              ($urandom_range(0, 99) < rdy_pct));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
